// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: state encoding and the
// BCD preset table selected by the mode key.
package countdown_ctrl_pkg;

  localparam int PRESET_IDX_W = 2;
  localparam int PRESET_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } preset_t;

  // Entry 0 sits in the low byte: 10, 30, 45, 60 seconds.
  localparam logic [PRESET_COUNT-1:0][7:0] PRESET_TABLE = {8'h60, 8'h45, 8'h30, 8'h10};

  function automatic preset_t preset_of(input logic [PRESET_IDX_W-1:0] idx);
    return preset_t'(PRESET_TABLE[idx]);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debouncer for an active-low pushbutton; emits a
// single-cycle press pulse when a new low level has been stable long enough.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Count consecutive samples that disagree with the accepted level.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer control: debounced start/mode keys, run/pause/done FSM,
// one-second prescaler and preset selection for an external BCD datapath.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_mode,
  input  logic       count_zero,
  output logic       load,
  output logic [3:0] preset_tens,
  output logic [3:0] preset_ones,
  output logic       cnt_en,
  output logic [1:0] state,
  output logic       alarm
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_t                  state_q;
  logic [PRESET_IDX_W-1:0] idx;
  logic [PRESC_W-1:0]      presc;
  logic [PRESC_W-1:0]      presc_adv;
  logic                    presc_wrap;
  logic                    load_pending;
  logic                    start_press;
  logic                    mode_press;
  preset_t                 preset;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_start),
    .press (start_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode),
    .press (mode_press)
  );

  assign preset      = preset_of(idx);
  assign preset_tens = preset.tens;
  assign preset_ones = preset.ones;
  assign state       = state_q;

  assign presc_wrap = (presc == PRESC_W'(CLK_HZ - 1));
  assign presc_adv  = presc_wrap ? '0 : presc + PRESC_W'(1);

  // The prescaler steps on every edge that starts a RUN cycle (except entry
  // from IDLE), so a tick is only ever emitted into a RUN cycle and the
  // phase survives any number of pauses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx          <= '0;
      presc        <= '0;
      cnt_en       <= 1'b0;
      alarm        <= 1'b0;
      load         <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      cnt_en       <= 1'b0;
      load         <= load_pending;
      load_pending <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          presc <= '0;
          if (start_press) begin
            state_q <= ST_RUN;
          end else if (mode_press) begin
            idx  <= idx + PRESET_IDX_W'(1);
            load <= 1'b1;
          end
        end
        ST_RUN: begin
          if (count_zero) begin
            state_q <= ST_DONE;
            alarm   <= 1'b1;
            presc   <= '0;
          end else if (start_press) begin
            state_q <= ST_PAUSE;
          end else begin
            presc  <= presc_adv;
            cnt_en <= presc_wrap;
          end
        end
        ST_PAUSE: begin
          if (start_press) begin
            state_q <= ST_RUN;
            presc   <= presc_adv;
            cnt_en  <= presc_wrap & ~count_zero;
          end
        end
        ST_DONE: begin
          presc <= '0;
          if (start_press) begin
            state_q <= ST_IDLE;
            alarm   <= 1'b0;
            load    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random key/count_zero
// activity, compared every cycle against a behavioural model.
module tb_countdown_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       key_start  = 1'b1;
  logic       key_mode   = 1'b1;
  logic       count_zero = 1'b0;
  logic       load;
  logic       cnt_en;
  logic       alarm;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];

  countdown_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start   (key_start),
    .key_mode    (key_mode),
    .count_zero  (count_zero),
    .load        (load),
    .preset_tens (preset_tens),
    .preset_ones (preset_ones),
    .cnt_en      (cnt_en),
    .state       (state),
    .alarm       (alarm)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int preset_val(input int i);
    case (i)
      0: return 10;
      1: return 30;
      2: return 45;
      default: return 60;
    endcase
  endfunction

  // ---------------- behavioural reference model ----------------
  bit m_valid = 0;
  int m_state, m_idx, m_since, m_lvl_s, m_lvl_m;
  bit m_ps, m_pm, m_load, m_cnt, m_alarm, m_pending;
  bit hist_s[$];
  bit hist_m[$];

  // A key level is accepted once the last DB samples leaving the two-flop
  // synchroniser all agree on a value different from the current level.
  // Returns the new level, or -1 if nothing is accepted.
  function automatic int db_accept(input bit h[$], input int lvl);
    int n;
    bit v;
    n = h.size();
    v = h[n-3];
    for (int j = 0; j < DB; j++) if (h[n-3-j] != v) return -1;
    if (int'(v) == lvl) return -1;
    return int'(v);
  endfunction

  task automatic run_cycle();
    m_since++;
    if (m_since == CLK_HZ) begin
      m_since = 0;
      m_cnt   = !count_zero;
    end
  endtask

  always @(posedge clk) begin
    int lv;
    bit ps, pm;
    int v;
    m_valid = 1;
    if (!rst_n) begin
      m_state = 0; m_idx = 0; m_since = 0;
      m_load = 0; m_cnt = 0; m_alarm = 0; m_pending = 1;
      m_ps = 0; m_pm = 0; m_lvl_s = 1; m_lvl_m = 1;
      hist_s.delete();
      hist_m.delete();
      for (int i = 0; i < DB + 2; i++) begin
        hist_s.push_back(1'b1);
        hist_m.push_back(1'b1);
      end
    end else begin
      ps = m_ps;
      pm = m_pm;
      hist_s.push_back(key_start);
      void'(hist_s.pop_front());
      hist_m.push_back(key_mode);
      void'(hist_m.pop_front());
      m_ps = 0;
      lv = db_accept(hist_s, m_lvl_s);
      if (lv >= 0) begin m_lvl_s = lv; m_ps = (lv == 0); end
      m_pm = 0;
      lv = db_accept(hist_m, m_lvl_m);
      if (lv >= 0) begin m_lvl_m = lv; m_pm = (lv == 0); end

      m_load = m_pending;
      m_pending = 0;
      m_cnt = 0;
      case (m_state)
        0: if (ps) begin m_state = 1; m_since = 0; end
           else if (pm) begin m_idx = (m_idx + 1) % 4; m_load = 1; end
        1: if (count_zero) m_state = 3;
           else if (ps) m_state = 2;
           else run_cycle();
        2: if (ps) begin m_state = 1; run_cycle(); end
        default: if (ps) begin m_state = 0; m_load = 1; end
      endcase
      m_alarm = (m_state == 3);
      if (m_load) begin
        v = preset_val(m_idx);
        exp_q.push_back({4'(v / 10), 4'(v % 10)});
      end
    end
  end

  // per-cycle scoreboard
  always @(negedge clk) begin
    if (m_valid) begin
      check("state", int'(state), m_state);
      check("load", int'(load), int'(m_load));
      check("cnt_en", int'(cnt_en), int'(m_cnt));
      check("alarm", int'(alarm), int'(m_alarm));
      check("preset", int'(preset_tens) * 10 + int'(preset_ones), preset_val(m_idx));
      if (load) begin
        if (exp_q.size() == 0) check("load_unexpected", int'(load), 0);
        else check("load_preset", int'({preset_tens, preset_ones}), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, output int loads, output int ticks);
    loads = 0;
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (load) loads++;
      if (cnt_en) ticks++;
    end
  endtask

  task automatic wait_state(input int v, input int limit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (int'(state) == v) begin at = cyc; break; end
    end
    if (at < 0) check({tag, "_timeout"}, int'(state), v);
  endtask

  task automatic wait_tick(input int limit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cnt_en) begin at = cyc; break; end
    end
    if (at < 0) check({tag, "_timeout"}, int'(cnt_en), 1);
  endtask

  task automatic press(input bit s, input bit m, input int hold);
    if (s) key_start = 1'b0;
    if (m) key_mode = 1'b0;
    step(hold);
    key_start = 1'b1;
    key_mode  = 1'b1;
    step(DB + 4);
  endtask

  task automatic bounce(input bit s);
    repeat (2) begin
      if (s) key_start = 1'b0; else key_mode = 1'b0;
      step(int'($urandom_range(1, DB - 1)));
      key_start = 1'b1;
      key_mode  = 1'b1;
      step(int'($urandom_range(1, 3)));
    end
    step(DB + 4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t, tp, tr, tt, l, tk, l2, tk2, op;
    int exp_p[4];
    exp_p = '{30, 45, 60, 10};

    step(3);
    rst_n = 1'b1;
    watch(4, l, tk);
    check("reset_load_count", l, 1);
    check("reset_state", int'(state), 0);
    check("reset_preset", int'(preset_tens) * 10 + int'(preset_ones), 10);
    check("reset_cnt_en", tk, 0);

    for (int i = 0; i < 4; i++) begin
      key_mode = 1'b0;
      watch(8, l, tk);
      key_mode = 1'b1;
      watch(8, l2, tk2);
      check($sformatf("mode%0d_loads", i), l + l2, 1);
      check($sformatf("mode%0d_preset", i), int'(preset_tens) * 10 + int'(preset_ones), exp_p[i]);
    end

    key_start = 1'b0;
    wait_state(1, 20, "start", t0);
    key_start = 1'b1;
    wait_tick(20, "tick1", t);
    check("tick1_latency", t - t0, 10);
    wait_tick(20, "tick2", t);
    check("tick2_latency", t - t0, 20);
    wait_tick(20, "tick3", t);
    check("tick3_latency", t - t0, 30);

    // Pause so that the press lands after four RUN cycles of a period.
    step(7);
    key_start = 1'b0;
    wait_state(2, 20, "pause", tp);
    check("pause_entry", tp - t, 14);
    key_start = 1'b1;
    step(50);
    check("pause_hold", int'(state), 2);
    key_start = 1'b0;
    wait_state(1, 20, "resume", tr);
    key_start = 1'b1;
    wait_tick(20, "resume_tick", tt);
    check("resume_latency", tt - tr, 6);

    // count_zero rises in the same cycle the start press reaches the FSM.
    key_start = 1'b0;
    step(6);
    count_zero = 1'b1;
    step(1);
    check("zero_state", int'(state), 3);
    check("zero_alarm", int'(alarm), 1);
    check("zero_cnt_en", int'(cnt_en), 0);
    key_start = 1'b1;
    watch(20, l, tk);
    check("done_ticks", tk, 0);
    check("done_hold", int'(state), 3);
    key_start = 1'b0;
    wait_state(0, 20, "ack", t);
    check("ack_load", int'(load), 1);
    check("ack_alarm", int'(alarm), 0);
    key_start = 1'b1;
    count_zero = 1'b0;
    step(10);

    key_mode = 1'b0; step(3);
    key_mode = 1'b1; step(2);
    key_mode = 1'b0; step(2);
    key_mode = 1'b1;
    watch(12, l, tk);
    check("bounce_loads", l, 0);
    check("bounce_preset", int'(preset_tens) * 10 + int'(preset_ones), 10);

    key_start = 1'b0;
    wait_state(1, 20, "run2", t);
    key_start = 1'b1;
    step(8);
    key_mode = 1'b0;
    watch(8, l, tk);
    key_mode = 1'b1;
    watch(8, l2, tk2);
    check("run_mode_loads", l + l2, 0);
    check("run_mode_preset", int'(preset_tens) * 10 + int'(preset_ones), 10);
    check("run_mode_state", int'(state), 1);

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    watch(30, l, tk);
    check("reset_run_ticks", tk, 0);
    check("reset_run_loads", l, 1);
    check("reset_run_state", int'(state), 0);

    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3: press(1'b1, 1'b0, int'($urandom_range(5, 12)));
        4, 5:       press(1'b0, 1'b1, int'($urandom_range(5, 12)));
        6:          press(1'b1, 1'b1, int'($urandom_range(5, 12)));
        7:          bounce(1'($urandom_range(0, 1)));
        8:          count_zero = ($urandom_range(0, 2) == 0);
        default: begin
          rst_n = 1'b0;
          step(int'($urandom_range(1, 3)));
          rst_n = 1'b1;
        end
      endcase
      step(int'($urandom_range(0, 25)));
    end

    step(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
